bsg_cgol_frame_ctrl: RTL and testbench

Sequences one Game-of-Life job through the cell-array datapath. It accepts a job (frame count) from the input channel and pulses the cell array to load the initial board. It then enables exactly N generation steps and offers the resulting board to the output data channel through a valid/yumi handshake. It sits between the input unpacker and the cell array / output data channel, and owns all datapath sequencing.

---
 rtl/bsg_cgol_frame_ctrl_if.sv | 41 ++++
 rtl/bsg_cgol_frame_ctrl.sv | 99 +++++++++
 tb/tb_bsg_cgol_frame_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bsg_cgol_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// bsg_cgol_frame_ctrl_if
//   Groups the job input channel, the cell-array control strobes, the final
//   board output channel and the status outputs of bsg_cgol_frame_ctrl.
//
//   frames_i    job generation count (valid with v_i)
//   v_i         job valid; initial board presented to the cell array
//   yumi_o      job consumed this cycle
//   update_o    cell array loads the initial board this cycle
//   en_o        cell array advances one generation this cycle
//   v_o         final board valid toward the output data channel
//   yumi_i      output data channel consumed the final board
//   busy_o      a job is in progress
//   gen_count_o generations completed in the current or last job
//
//   slave  : the frame controller
//   master : the environment (unpacker / cell array / output channel)
// ---------------------------------------------------------------------------
interface bsg_cgol_frame_ctrl_if #(
   parameter int unsigned frame_width_p = 16
);
   logic [frame_width_p-1:0] frames_i;
   logic                     v_i;
   logic                     yumi_o;
   logic                     update_o;
   logic                     en_o;
   logic                     v_o;
   logic                     yumi_i;
   logic                     busy_o;
   logic [frame_width_p-1:0] gen_count_o;

   modport slave (
      input  frames_i, v_i, yumi_i,
      output yumi_o, update_o, en_o, v_o, busy_o, gen_count_o
   );

   modport master (
      output frames_i, v_i, yumi_i,
      input  yumi_o, update_o, en_o, v_o, busy_o, gen_count_o
   );
endinterface

// File: rtl/bsg_cgol_frame_ctrl.sv
// ---------------------------------------------------------------------------
// bsg_cgol_frame_ctrl
//   Sequences one Game-of-Life job through the cell-array datapath: accepts a
//   job (generation count), pulses the array to load the initial board, runs
//   exactly that many generation steps, then offers the final board to the
//   output channel with a valid/yumi handshake.
//
//   clk_i    clock
//   reset_i  synchronous active-high reset; forces every output to 0
//   io       bsg_cgol_frame_ctrl_if.slave (job in, cell-array strobes,
//            board out, status)
// ---------------------------------------------------------------------------
module bsg_cgol_frame_ctrl #(
   parameter int unsigned frame_width_p = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   bsg_cgol_frame_ctrl_if.slave  io
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [frame_width_p-1:0] one_lp = frame_width_p'(1);

   state_e                   state_r, state_n;
   logic [frame_width_p-1:0] frames_left_r, frames_left_n;
   logic [frame_width_p-1:0] gen_count_r, gen_count_n;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r       <= IDLE;
         frames_left_r <= '0;
         gen_count_r   <= '0;
      end else begin
         state_r       <= state_n;
         frames_left_r <= frames_left_n;
         gen_count_r   <= gen_count_n;
      end
   end

   always_comb begin
      state_n       = state_r;
      frames_left_n = frames_left_r;
      gen_count_n   = gen_count_r;
      io.yumi_o     = 1'b0;
      io.update_o   = 1'b0;
      io.en_o       = 1'b0;
      io.v_o        = 1'b0;
      io.busy_o     = 1'b0;

      unique case (state_r)
         IDLE: begin
            io.yumi_o   = io.v_i;
            io.update_o = io.v_i;
            if (io.v_i) begin
               frames_left_n = io.frames_i;
               gen_count_n   = '0;
               // A zero-generation job hands back the loaded board unchanged.
               state_n       = (io.frames_i != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            io.en_o       = 1'b1;
            io.busy_o     = 1'b1;
            frames_left_n = frames_left_r - one_lp;
            gen_count_n   = gen_count_r + one_lp;
            if (frames_left_r == one_lp) state_n = DONE;
         end
         DONE: begin
            io.v_o    = 1'b1;
            io.busy_o = 1'b1;
            // No bypass to a new load: the board is held while the output drains.
            if (io.yumi_i) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase

      // Reset overrides every output, including the combinational job yumi.
      if (reset_i) begin
         io.yumi_o   = 1'b0;
         io.update_o = 1'b0;
         io.en_o     = 1'b0;
         io.v_o      = 1'b0;
         io.busy_o   = 1'b0;
      end
   end

   assign io.gen_count_o = reset_i ? '0 : gen_count_r;

   // The output channel may only consume a board that is being offered.
   yumi_only_in_done: assert property (
      @(posedge clk_i) disable iff (reset_i) io.yumi_i |-> (state_r == DONE)
   );

endmodule

// File: tb/tb_bsg_cgol_frame_ctrl.sv
module tb_bsg_cgol_frame_ctrl;

   localparam int unsigned W = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bsg_cgol_frame_ctrl_if #(.frame_width_p(W)) io ();

   bsg_cgol_frame_ctrl #(.frame_width_p(W)) dut (
      .clk_i   (clk),
      .reset_i (reset),
      .io      (io)
   );

   int vectors = 0;
   int miscompares = 0;

   // Reference model: a job is remembered by its accept cycle and length;
   // expected outputs follow from the cycle offset since accept.
   int  cyc = -1;
   bit  active = 0;
   int  acc_c = 0;
   int  job_n = 0;
   int  last_gen = 0;
   bit  cur_r = 1, cur_v = 0, cur_y = 0;
   logic [W-1:0] cur_f = '0;
   logic [5+W-1:0] exp_vec;

   function automatic logic [5+W-1:0] observed();
      return {io.yumi_o, io.update_o, io.en_o, io.v_o, io.busy_o, io.gen_count_o};
   endfunction

   // Advance one cycle: retire the previous cycle into the model, drive new
   // inputs, compute the expected outputs, then wait to the sampling point.
   task automatic step(input bit r, input bit v, input logic [W-1:0] f, input bit y);
      int t;
      bit e_yumi, e_en, e_vo, e_busy;
      int e_gen;
      @(posedge clk);
      if (cur_r) begin
         active = 0; last_gen = 0;
      end else if (!active) begin
         if (cur_v) begin active = 1; acc_c = cyc; job_n = int'(cur_f); end
      end else if ((cyc - acc_c) >= job_n + 1 && cur_y) begin
         active = 0; last_gen = job_n;
      end
      cyc++;
      #1;
      e_yumi = 0; e_en = 0; e_vo = 0; e_busy = 0; e_gen = last_gen;
      if (active) begin
         t = cyc - acc_c;
         e_busy = 1;
         e_en = (t <= job_n);
         e_vo = (t >= job_n + 1);
         e_gen = (t - 1 < job_n) ? t - 1 : job_n;
      end else begin
         e_yumi = v;
      end
      // yumi toward the DUT only while a board is actually offered
      cur_r = r; cur_v = v; cur_f = f; cur_y = y && e_vo && !r;
      reset = cur_r; io.v_i = cur_v; io.frames_i = cur_f; io.yumi_i = cur_y;
      if (r) exp_vec = '0;
      else   exp_vec = {e_yumi, e_yumi, e_en, e_vo, e_busy, W'(e_gen)};
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 4'h5, 0);
         vectors++;
         if (observed() !== exp_vec) begin
            miscompares++;
            $display("FAIL reset cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
         end
      end
      step(0, 0, 4'h0, 0);
      vectors++;
      if (observed() !== exp_vec) begin
         miscompares++;
         $display("FAIL reset_idle cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
      end
   endtask

   task automatic test_job3();
      int en_cnt = 0;
      step(0, 1, 4'd3, 0);
      vectors++;
      if (observed() !== exp_vec) begin
         miscompares++;
         $display("FAIL job3_accept cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
      end
      for (int i = 0; i < 7; i++) begin
         step(0, 0, 4'd0, i == 5);
         en_cnt += int'(io.en_o);
         vectors++;
         if (observed() !== exp_vec) begin
            miscompares++;
            $display("FAIL job3 cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
         end
      end
      vectors++;
      if (en_cnt !== 3) begin
         miscompares++;
         $display("FAIL job3_en_count got=%0d exp=3", en_cnt);
      end
   endtask

   task automatic test_zero();
      for (int i = 0; i < 3; i++) begin
         step(0, i == 0, 4'd0, i == 1);
         vectors++;
         if (observed() !== exp_vec) begin
            miscompares++;
            $display("FAIL zero cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
         end
      end
   endtask

   task automatic test_backpressure();
      step(0, 1, 4'd2, 0);
      // two RUN cycles, then DONE held for 12 cycles with a new job pending
      for (int i = 0; i < 14; i++) begin
         step(0, 1, 4'd7, 0);
         vectors++;
         if (observed() !== exp_vec) begin
            miscompares++;
            $display("FAIL hold cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
         end
      end
      step(0, 1, 4'd7, 1);
      step(0, 1, 4'd7, 0);
      vectors++;
      if (io.yumi_o !== 1'b1 || observed() !== exp_vec) begin
         miscompares++;
         $display("FAIL pending_accept cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
      end
      for (int i = 0; i < 9; i++) begin
         step(0, 0, 4'd0, 1);
         vectors++;
         if (observed() !== exp_vec) begin
            miscompares++;
            $display("FAIL drain7 cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
         end
      end
   endtask

   task automatic test_reset_mid();
      int vo_cnt = 0;
      step(0, 1, 4'd5, 0);
      step(0, 0, 4'd0, 0);
      step(1, 1, 4'd9, 0);
      vectors++;
      if (observed() !== exp_vec) begin
         miscompares++;
         $display("FAIL reset_mid cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
      end
      step(1, 0, 4'd0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, i == 0, 4'd1, i == 2);
         vo_cnt += int'(io.v_o);
         vectors++;
         if (observed() !== exp_vec) begin
            miscompares++;
            $display("FAIL after_reset cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
         end
      end
      vectors++;
      if (vo_cnt !== 1) begin
         miscompares++;
         $display("FAIL after_reset_vo_count got=%0d exp=1", vo_cnt);
      end
   endtask

   task automatic test_back_to_back();
      int en_a = 0, en_b = 0;
      step(0, 1, 4'd15, 0);
      // v_i held with frames=1 throughout; accepted only once back in IDLE
      for (int i = 0; i < 16; i++) begin
         step(0, 1, 4'd1, 1);
         en_a += int'(io.en_o);
         vectors++;
         if (observed() !== exp_vec) begin
            miscompares++;
            $display("FAIL max15 cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
         end
      end
      vectors++;
      if (io.gen_count_o !== 4'd15) begin
         miscompares++;
         $display("FAIL max15_gen got=%0d exp=15", io.gen_count_o);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, i == 0, 4'd1, 1);
         en_b += int'(io.en_o);
         vectors++;
         if (observed() !== exp_vec) begin
            miscompares++;
            $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
         end
      end
      vectors++;
      if (en_a !== 15 || en_b !== 1) begin
         miscompares++;
         $display("FAIL b2b_en_counts got=%0d,%0d exp=15,1", en_a, en_b);
      end
   endtask

   task automatic test_ignore_inputs();
      int en_cnt = 0;
      step(0, 1, 4'd4, 0);
      for (int i = 0; i < 7; i++) begin
         step(0, (i < 4) ? ~i[0] : 1'b0, 4'd9, i == 4);
         en_cnt += int'(io.en_o);
         vectors++;
         if (observed() !== exp_vec) begin
            miscompares++;
            $display("FAIL ignore cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
         end
      end
      vectors++;
      if (en_cnt !== 4) begin
         miscompares++;
         $display("FAIL ignore_en_count got=%0d exp=4", en_cnt);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         step(($urandom % 60) == 0, ($urandom % 3) == 0, W'($urandom), ($urandom % 3) == 0);
         vectors++;
         if (observed() !== exp_vec) begin
            miscompares++;
            $display("FAIL random cyc=%0d got=%h exp=%h", cyc, observed(), exp_vec);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      io.v_i = 1'b0;
      io.frames_i = '0;
      io.yumi_i = 1'b0;
      test_reset();
      test_job3();
      test_zero();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_ignore_inputs();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
